// File: rtl/rv32_dmem_pkg.sv
// rtl/rv32_dmem_pkg.sv - shared widths, state encoding and defaults for the RV32 data-memory responder
package rv32_dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    localparam logic [31:0] DEFAULT_TCM_BASE = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESP    = 3'd1,
        ST_EXT_WR  = 3'd2,
        ST_EXT_RD  = 3'd3,
        ST_EXT_RDW = 3'd4
    } state_e;

endpackage

// File: rtl/rv32_dmem_tcm.sv
// rtl/rv32_dmem_tcm.sv - 2^AW x 32 single-port RAM, byte write enables, registered read (old data on collision)
module rv32_dmem_tcm
    import rv32_dmem_pkg::*;
#(
    parameter int unsigned AW = 12
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [BE_W-1:0]   we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**AW];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(BE_W); b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - RV32 load/store responder: local TCM plus external bus bridge when RV32_DMEM_EXT_EN is defined
module rv32_dmem_responder
    import rv32_dmem_pkg::*;
#(
    parameter int unsigned TCM_AW   = 12,
    parameter logic [31:0] TCM_BASE = DEFAULT_TCM_BASE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WORD_W-1:0] addr,
    input  logic [BE_W-1:0]   st_be,
    input  logic [WORD_W-1:0] wdata,
    input  logic              load,
    input  logic              store,
    output logic [WORD_W-1:0] ld_data,
    output logic              stall,
    output logic [WORD_W-1:0] ext_address,
    output logic              ext_read,
    output logic              ext_write,
    output logic [WORD_W-1:0] ext_writedata,
    output logic [BE_W-1:0]   ext_byteenable,
    input  logic              ext_waitrequest,
    input  logic [WORD_W-1:0] ext_readdata,
    input  logic              ext_readdatavalid
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] ld_q, ld_d;
    logic              tcm_hit;
    logic              src_ext;
    logic              tcm_re;
    logic [BE_W-1:0]   tcm_we;
    logic [WORD_W-1:0] tcm_rdata;

`ifdef RV32_DMEM_EXT_EN
    logic                src_ext_q, src_ext_d;
    logic [WORD_W-1:2]   ext_addr_q, ext_addr_d;
    logic [WORD_W-1:0]   ext_wdata_q, ext_wdata_d;
    logic [BE_W-1:0]     ext_be_q, ext_be_d;
    logic                unused_lsb;

    assign tcm_hit        = (addr[WORD_W-1:TCM_AW+2] == TCM_BASE[WORD_W-1:TCM_AW+2]);
    assign src_ext        = src_ext_q;
    assign ext_address    = {ext_addr_q, 2'b00};
    assign ext_read       = (state_q == ST_EXT_RD);
    assign ext_write      = (state_q == ST_EXT_WR);
    assign ext_writedata  = ext_wdata_q;
    assign ext_byteenable = ext_read ? {BE_W{1'b1}} : ext_be_q;
    assign unused_lsb     = ^addr[1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_ext_q   <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            ext_be_q    <= '0;
        end else begin
            src_ext_q   <= src_ext_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            ext_be_q    <= ext_be_d;
        end
    end
`else
    logic unused_ext;

    // Whole address space aliases onto the TCM.
    assign tcm_hit        = 1'b1;
    assign src_ext        = 1'b0;
    assign ext_address    = '0;
    assign ext_read       = 1'b0;
    assign ext_write      = 1'b0;
    assign ext_writedata  = '0;
    assign ext_byteenable = '0;
    assign unused_ext     = ^{ext_waitrequest, ext_readdata, ext_readdatavalid,
                              addr[WORD_W-1:TCM_AW+2], addr[1:0], TCM_BASE};
`endif

    // In RESP a TCM load presents the RAM output directly; everything else shows the held word.
    assign ld_data = (state_q == ST_RESP && !src_ext) ? tcm_rdata : ld_q;

    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        tcm_re  = 1'b0;
        tcm_we  = '0;
        stall   = 1'b0;
`ifdef RV32_DMEM_EXT_EN
        src_ext_d   = src_ext_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        ext_be_d    = ext_be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    stall = 1'b1;
`ifdef RV32_DMEM_EXT_EN
                    src_ext_d  = !tcm_hit;
                    ext_addr_d = addr[WORD_W-1:2];
`endif
                    if (tcm_hit) begin
                        tcm_re  = 1'b1;
                        state_d = ST_RESP;
                    end
`ifdef RV32_DMEM_EXT_EN
                    else begin
                        state_d = ST_EXT_RD;
                    end
`endif
                end else if (store) begin
                    if (tcm_hit) begin
                        tcm_we = st_be;
                    end
`ifdef RV32_DMEM_EXT_EN
                    else begin
                        ext_addr_d  = addr[WORD_W-1:2];
                        ext_wdata_d = wdata;
                        ext_be_d    = st_be;
                        state_d     = ST_EXT_WR;
                    end
`endif
                end
            end
            ST_RESP: begin
                ld_d    = ld_data;
                state_d = ST_IDLE;
            end
`ifdef RV32_DMEM_EXT_EN
            ST_EXT_WR: begin
                stall = 1'b1;
                if (!ext_waitrequest) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXT_RD: begin
                stall = 1'b1;
                if (ext_readdatavalid) begin
                    ld_d    = ext_readdata;
                    state_d = ST_RESP;
                end else if (!ext_waitrequest) begin
                    state_d = ST_EXT_RDW;
                end
            end
            ST_EXT_RDW: begin
                stall = 1'b1;
                if (ext_readdatavalid) begin
                    ld_d    = ext_readdata;
                    state_d = ST_RESP;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
        end
    end

    rv32_dmem_tcm #(
        .AW (TCM_AW)
    ) u_tcm (
        .clk     (clk),
        .re_i    (tcm_re & reset_n),
        .we_i    (tcm_we & {BE_W{reset_n}}),
        .addr_i  (addr[TCM_AW+1:2]),
        .wdata_i (wdata),
        .rdata_o (tcm_rdata)
    );

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - self-checking bench: vector table, hand sequences, randomized TCM traffic vs word model
module tb_rv32_dmem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [3:0]  st_be;
    logic [31:0] wdata;
    logic        load;
    logic        store;
    logic [31:0] ld_data;
    logic        stall;
    logic [31:0] ext_address;
    logic        ext_read;
    logic        ext_write;
    logic [31:0] ext_writedata;
    logic [3:0]  ext_byteenable;
    logic        ext_waitrequest;
    logic [31:0] ext_readdata;
    logic        ext_readdatavalid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [16];

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    rv32_dmem_responder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .addr              (addr),
        .st_be             (st_be),
        .wdata             (wdata),
        .load              (load),
        .store             (store),
        .ld_data           (ld_data),
        .stall             (stall),
        .ext_address       (ext_address),
        .ext_read          (ext_read),
        .ext_write         (ext_write),
        .ext_writedata     (ext_writedata),
        .ext_byteenable    (ext_byteenable),
        .ext_waitrequest   (ext_waitrequest),
        .ext_readdata      (ext_readdata),
        .ext_readdatavalid (ext_readdatavalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (d & m);
    endfunction

    // One core request: loads are checked at issue, in the response cycle and one cycle after.
    task automatic do_op(input logic ld, input logic st, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp, input string nm);
        load  = ld;
        store = st;
        addr  = a;
        st_be = be;
        wdata = wd;
        #1;
        if (ld) begin
            chk1({nm, " issue stall"}, stall, 1'b1);
            tick();
            store = 1'b0;
            #1;
            chk1({nm, " resp stall"}, stall, 1'b0);
            chk({nm, " resp ld_data"}, ld_data, exp);
            load = 1'b0;
            tick();
            chk({nm, " hold ld_data"}, ld_data, exp);
        end else begin
            chk1({nm, " stall"}, stall, 1'b0);
            tick();
            load  = 1'b0;
            store = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [3:0]  idx;
        int          op;
        int          cnt;

        reset_n = 1'b0;
        addr = '0; st_be = '0; wdata = '0; load = 1'b0; store = 1'b0;
        ext_waitrequest = 1'b0; ext_readdata = '0; ext_readdatavalid = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk1("reset stall", stall, 1'b0);
        chk("reset ld_data", ld_data, 32'h0);
        chk1("reset ext_read", ext_read, 1'b0);
        chk1("reset ext_write", ext_write, 1'b0);

        vecs.push_back('{1'b0, 1'b1, 32'h10,   4'hf, 32'h0000_0000, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   4'h3, 32'hA5A5_A5A5, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h10,   4'h0, 32'h0,         32'h0000_A5A5});
        vecs.push_back('{1'b0, 1'b1, 32'h0,    4'hf, 32'h0000_0001, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,    4'hf, 32'h0000_0002, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   4'h0, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h10,   4'h0, 32'h0,         32'h0000_A5A5});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   4'h8, 32'h1200_0000, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h10,   4'h0, 32'h0,         32'h1200_A5A5});
        vecs.push_back('{1'b0, 1'b1, 32'h3FFC, 4'hf, 32'hCAFE_F00D, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h3FFC, 4'h0, 32'h0,         32'hCAFE_F00D});
        vecs.push_back('{1'b0, 1'b1, 32'h20,   4'hf, 32'h1111_1111, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h20,   4'hf, 32'h0000_0055, 32'h1111_1111});
        vecs.push_back('{1'b1, 1'b0, 32'h20,   4'h0, 32'h0,         32'h1111_1111});

        foreach (vecs[i]) begin
            do_op(vecs[i].ld, vecs[i].st, vecs[i].a, vecs[i].be, vecs[i].wd, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Back-to-back loads: the second request appears in the cycle after RESP.
        load = 1'b1; addr = 32'h0;
        #1;
        chk1("b2b first issue stall", stall, 1'b1);
        tick();
        chk1("b2b first resp stall", stall, 1'b0);
        chk("b2b first ld_data", ld_data, 32'h1);
        tick();
        addr = 32'h4;
        #1;
        chk1("b2b second issue stall", stall, 1'b1);
        chk("b2b held ld_data", ld_data, 32'h1);
        tick();
        chk1("b2b second resp stall", stall, 1'b0);
        chk("b2b second ld_data", ld_data, 32'h2);
        load = 1'b0;
        tick();

`ifdef RV32_DMEM_EXT_EN
        // External load: three waitrequest cycles, data two cycles after acceptance.
        load = 1'b1; addr = 32'h8000_0000;
        #1;
        chk1("extrd issue stall", stall, 1'b1);
        chk1("extrd issue no read", ext_read, 1'b0);
        tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            ext_waitrequest = (i < 3);
            #1;
            if (ext_read) cnt++;
            chk1("extrd stall", stall, 1'b1);
            chk("extrd address", ext_address, 32'h8000_0000);
            chk("extrd byteenable", {28'h0, ext_byteenable}, 32'hf);
            tick();
        end
        ext_waitrequest = 1'b0;
        chk("extrd read cycles", cnt, 4);
        #1;
        chk1("extrdw read low", ext_read, 1'b0);
        chk1("extrdw stall", stall, 1'b1);
        tick();
        ext_readdatavalid = 1'b1; ext_readdata = 32'hDEAD_BEEF;
        #1;
        chk1("extrdw valid stall", stall, 1'b1);
        tick();
        ext_readdatavalid = 1'b0; ext_readdata = 32'h0;
        #1;
        chk1("extrd resp stall", stall, 1'b0);
        chk("extrd resp ld_data", ld_data, 32'hDEAD_BEEF);
        load = 1'b0;
        tick();
        chk("extrd hold ld_data", ld_data, 32'hDEAD_BEEF);

        // External store: strobe, data and address held through two waitrequest cycles.
        store = 1'b1; addr = 32'h8000_0004; wdata = 32'h1234_5678; st_be = 4'hf;
        #1;
        chk1("extwr issue stall", stall, 1'b0);
        tick();
        store = 1'b0; addr = 32'h0; wdata = 32'hFFFF_FFFF; st_be = 4'h0;
        for (int i = 0; i < 3; i++) begin
            ext_waitrequest = (i < 2);
            #1;
            chk1("extwr write", ext_write, 1'b1);
            chk1("extwr stall", stall, 1'b1);
            chk("extwr address", ext_address, 32'h8000_0004);
            chk("extwr data", ext_writedata, 32'h1234_5678);
            chk("extwr byteenable", {28'h0, ext_byteenable}, 32'hf);
            tick();
        end
        ext_waitrequest = 1'b0;
        #1;
        chk1("extwr done write", ext_write, 1'b0);
        chk1("extwr done stall", stall, 1'b0);

        // Reset while waiting for read data; the late valid must be ignored.
        load = 1'b1; addr = 32'h8000_0008;
        tick();
        tick();
        reset_n = 1'b0; load = 1'b0;
        tick();
        chk1("rst ext_read", ext_read, 1'b0);
        chk1("rst stall", stall, 1'b0);
        chk("rst ld_data", ld_data, 32'h0);
        reset_n = 1'b1;
        ext_readdatavalid = 1'b1; ext_readdata = 32'h9999_9999;
        tick();
        ext_readdatavalid = 1'b0;
        #1;
        chk("rst late valid ld_data", ld_data, 32'h0);
        chk1("rst late valid stall", stall, 1'b0);
        do_op(1'b1, 1'b0, 32'h3FFC, 4'h0, 32'h0, 32'hCAFE_F00D, "post-rst tcm load");
`else
        // Every address aliases into the TCM; the bus side stays quiet.
        do_op(1'b0, 1'b1, 32'h8000_0010, 4'hf, 32'h7, 32'h0, "alias store");
        chk1("alias ext_write", ext_write, 1'b0);
        do_op(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h7, "alias load");
        chk1("alias ext_read", ext_read, 1'b0);
        chk("alias ext_address", ext_address, 32'h0);
        chk("alias ext_writedata", ext_writedata, 32'h0);
`endif

        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model[i] = wd;
            do_op(1'b0, 1'b1, 32'(i) << 2, 4'hf, wd, 32'h0, "rnd init");
        end

        for (int n = 0; n < 300; n++) begin
            r   = $urandom;
            idx = 4'($urandom_range(0, 15));
`ifdef RV32_DMEM_EXT_EN
            a = {18'd0, 8'd0, idx, 2'b00};
`else
            a = {r[31:14], 8'd0, idx, 2'b00};
`endif
            be = 4'($urandom);
            wd = $urandom;
            op = $urandom_range(0, 3);
            case (op)
                0: do_op(1'b0, 1'b0, a, be, wd, 32'h0, "rnd idle");
                1: begin
                    do_op(1'b0, 1'b1, a, be, wd, 32'h0, "rnd store");
                    model[idx] = merge(model[idx], wd, be);
                end
                default: do_op(1'b1, (op == 3), a, be, wd, model[idx],
                               $sformatf("rnd load w%0d", idx));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
